// File: rtl/mips_defs_pkg.sv
// mips_defs: shared definitions for the multi-cycle MIPS datapath.
//   - opcode constants seen on op = ir[31:26]
//   - pc_src encodings driven by the controller
//   - instruction-fetch FSM state encoding
package mips_defs;

    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_J      = 6'h02;

    typedef enum logic [1:0] {
        PC_SRC_RSVD   = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_HOLD   = 2'b11
    } pc_src_t;

    typedef enum logic [2:0] {
        F_IDLE = 3'd0,
        F_REQ  = 3'd1,
        F_WAIT = 3'd2,
        F_DONE = 3'd3,
        F_ERR  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational redirect-target select and load enable for the PC.
//   pc, jump_index, pc_src, branch_target -> pc_redir (word aligned)
//   pc_write, pc_write_cond, zero          -> pc_load
// Reserved pc_src codes select the current PC, so a load with them is a hold.
module pc_next_sel
    import mips_defs::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] jump_index,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        zero,
    output logic [31:0] pc_redir,
    output logic        pc_load
);

    logic [31:0] sel;

    always_comb begin
        sel = pc;
        case (pc_src_t'(pc_src))
            PC_SRC_BRANCH: sel = branch_target;
            PC_SRC_JUMP:   sel = {pc[31:28], jump_index, 2'b00};
            default:       sel = pc;
        endcase
        pc_redir = sel & ~32'h3;
    end

    assign pc_load = pc_write | (pc_write_cond & zero);

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage of the multi-cycle MIPS datapath.
//   clk, rst_n                 clock, async active-low reset
//   fetch_req                  start a fetch (sampled in IDLE only)
//   pc_write, pc_write_cond,
//   zero, pc_src,
//   branch_target              controller PC redirect
//   mem_addr, mem_rd           instruction memory read request
//   mem_rdata, mem_ack         instruction memory response
//   ir, op, ir_valid           instruction register, opcode, new-IR strobe
//   pc, busy, fetch_err        current PC, fetch in progress, sticky timeout
//
// state  | meaning
// F_IDLE | waiting for fetch_req
// F_REQ  | issue read at pc, latch request address, clear wait counter
// F_WAIT | read outstanding; ack captures IR and advances PC
// F_DONE | ir_valid pulse for one cycle
// F_ERR  | memory timeout; terminal until reset
module ifetch_unit
    import mips_defs::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        zero,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] ir,
    output logic [5:0]  op,
    output logic        ir_valid,
    output logic [31:0] pc,
    output logic        busy,
    output logic        fetch_err
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    fetch_state_t state_q, state_d;
    logic [7:0]   wait_cnt_q;
    logic [31:0]  pc_q;
    logic [31:0]  ir_q;
    logic [31:0]  req_addr_q;
    logic         fetch_err_q;

    logic [31:0]  pc_redir;
    logic         pc_load;
    logic         ack_take;
    logic         timeout;

    pc_next_sel u_pc_next_sel (
        .pc            (pc_q),
        .jump_index    (ir_q[25:0]),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .zero          (zero),
        .pc_redir      (pc_redir),
        .pc_load       (pc_load)
    );

    assign ack_take = (state_q == F_WAIT) && mem_ack;
    // An ack in the final allowed WAIT cycle still completes the fetch.
    assign timeout  = (state_q == F_WAIT) && !mem_ack && ((wait_cnt_q + 8'd1) == WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= F_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            F_IDLE: if (fetch_req) state_d = F_REQ;
            F_REQ:  state_d = F_WAIT;
            F_WAIT: begin
                if (mem_ack)      state_d = F_DONE;
                else if (timeout) state_d = F_ERR;
            end
            F_DONE: state_d = F_IDLE;
            F_ERR:  state_d = F_ERR;
            default: state_d = F_IDLE;
        endcase
    end

    // The request address is frozen in REQ so a redirect while the read is
    // outstanding cannot disturb the address memory is serving.
    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = 32'h0;
        busy     = 1'b0;
        ir_valid = 1'b0;
        case (state_q)
            F_REQ: begin
                mem_rd   = 1'b1;
                mem_addr = pc_q;
                busy     = 1'b1;
            end
            F_WAIT: begin
                mem_rd   = 1'b1;
                mem_addr = req_addr_q;
                busy     = 1'b1;
            end
            F_DONE:  ir_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q  <= 8'h0;
            req_addr_q  <= 32'h0;
            ir_q        <= 32'h0;
            pc_q        <= PC_RESET & ~32'h3;
            fetch_err_q <= 1'b0;
        end else begin
            if (state_q == F_REQ) begin
                wait_cnt_q <= 8'h0;
                req_addr_q <= pc_q;
            end else if (state_q == F_WAIT && !mem_ack) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end

            if (ack_take) ir_q <= mem_rdata;

            // Redirect beats the sequential increment in the ack cycle.
            if (state_q != F_ERR && pc_load) begin
                pc_q <= pc_redir;
            end else if (ack_take) begin
                pc_q <= (pc_q + 32'd4) & ~32'h3;
            end

            if (timeout) fetch_err_q <= 1'b1;
        end
    end

    assign pc        = pc_q;
    assign ir        = ir_q;
    assign op        = ir_q[31:26];
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic        pc_write;
    logic        pc_write_cond;
    logic        zero;
    logic [1:0]  pc_src;
    logic [31:0] branch_target;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] ir;
    logic [5:0]  op;
    logic        ir_valid;
    logic [31:0] pc;
    logic        busy;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;
    int cnt;
    logic addr_ok;

    ifetch_unit #(.PC_RESET(32'h0000_0000), .MAX_WAIT(15)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_req     (fetch_req),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .zero          (zero),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .ir            (ir),
        .op            (op),
        .ir_valid      (ir_valid),
        .pc            (pc),
        .busy          (busy),
        .fetch_err     (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        fetch_req     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        zero          = 1'b0;
        pc_src        = 2'b00;
        branch_target = 32'h0;
        mem_rdata     = 32'h0;
        mem_ack       = 1'b0;

        // reset values
        #3;
        chk("rst_pc",        pc,                     32'h0);
        chk("rst_ir",        ir,                     32'h0);
        chk("rst_op",        32'(op),                32'h0);
        chk("rst_mem_rd",    32'(mem_rd),            32'h0);
        chk("rst_mem_addr",  mem_addr,               32'h0);
        chk("rst_busy_err",  {30'h0, busy, fetch_err}, 32'h0);
        chk("rst_ir_valid",  32'(ir_valid),          32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ack outside WAIT is ignored
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        chk("ack_idle_ir", ir, 32'h0);
        chk("ack_idle_pc", pc, 32'h0);

        // 1: fetch with ack in first WAIT cycle
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("t1_req_rd",   32'(mem_rd), 32'h1);
        chk("t1_req_addr", mem_addr,    32'h0);
        chk("t1_req_busy", 32'(busy),   32'h1);
        tick();
        chk("t1_wait_rd",  32'(mem_rd),   32'h1);
        chk("t1_wait_iv",  32'(ir_valid), 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h8C22_0004;
        tick();
        mem_ack = 1'b0;
        chk("t1_iv",     32'(ir_valid), 32'h1);
        chk("t1_ir",     ir,            32'h8C22_0004);
        chk("t1_op",     32'(op),       32'h23);
        chk("t1_pc",     pc,            32'h4);
        chk("t1_done_rd", 32'(mem_rd),  32'h0);
        tick();
        chk("t1_iv_off", 32'(ir_valid), 32'h0);

        // 2: ack in fifth WAIT cycle; fetch_req while busy is dropped
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        cnt = 32'(mem_rd);
        addr_ok = (mem_addr === 32'h4);
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) fetch_req = 1'b1;
            if (i == 3) fetch_req = 1'b0;
            tick();
            cnt += 32'(mem_rd);
            addr_ok &= (mem_addr === 32'h4);
            if (i == 5) begin
                mem_ack = 1'b1; mem_rdata = 32'h0800_0010;
            end
        end
        tick();
        mem_ack = 1'b0;
        chk("t2_rd_cycles", 32'(cnt),     32'd6);
        chk("t2_addr_const", 32'(addr_ok), 32'h1);
        chk("t2_ir",        ir,           32'h0800_0010);
        chk("t2_op",        32'(op),      32'h02);
        chk("t2_pc",        pc,           32'h8);
        cnt = 32'(ir_valid);
        for (int i = 0; i < 3; i++) begin
            tick();
            cnt += 32'(ir_valid);
        end
        chk("t2_iv_pulses", 32'(cnt),  32'd1);
        chk("t2_no_queue",  32'(busy), 32'h0);

        // 4: jump, conditional branch not taken / taken, alignment, reserved src
        pc_write = 1'b1; pc_src = 2'b10;
        tick();
        pc_write = 1'b0;
        chk("t4_jump", pc, 32'h0000_0040);
        pc_write_cond = 1'b1; zero = 1'b0; pc_src = 2'b01; branch_target = 32'h200;
        tick();
        chk("t4_beq_nt", pc, 32'h0000_0040);
        zero = 1'b1;
        tick();
        pc_write_cond = 1'b0; zero = 1'b0;
        chk("t4_beq_t", pc, 32'h0000_0200);
        pc_write = 1'b1; branch_target = 32'h303;
        tick();
        chk("t4_align", pc, 32'h0000_0300);
        pc_src = 2'b11; branch_target = 32'h700;
        tick();
        pc_write = 1'b0;
        chk("t4_rsvd_hold", pc, 32'h0000_0300);

        // 5: redirect in the ack cycle wins over +4, IR still captured
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("t5_addr", mem_addr, 32'h300);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1000_0003;
        pc_write = 1'b1; pc_src = 2'b01; branch_target = 32'h100;
        tick();
        mem_ack = 1'b0; pc_write = 1'b0;
        chk("t5_ir", ir,      32'h1000_0003);
        chk("t5_op", 32'(op), 32'h04);
        chk("t5_pc", pc,      32'h100);
        tick();

        // redirect during REQ leaves the outstanding address alone
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        pc_write = 1'b1; pc_src = 2'b01; branch_target = 32'h500;
        tick();
        pc_write = 1'b0;
        chk("t5_req_redir_addr", mem_addr, 32'h100);
        chk("t5_req_redir_pc",   pc,       32'h500);
        mem_ack = 1'b1; mem_rdata = 32'hAC00_0000;
        tick();
        mem_ack = 1'b0;
        chk("t5_req_redir_inc", pc, 32'h504);
        tick();

        // 6: wrap from FFFF_FFFC
        pc_write = 1'b1; pc_src = 2'b01; branch_target = 32'hFFFF_FFFC;
        tick();
        pc_write = 1'b0;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("t6_wrap_addr", mem_addr, 32'hFFFF_FFFC);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0020;
        tick();
        mem_ack = 1'b0;
        chk("t6_wrap_pc", pc, 32'h0);
        tick();

        // 6: async reset during WAIT
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        pc_write = 1'b1; pc_src = 2'b01; branch_target = 32'h80;
        tick();
        pc_write = 1'b0;
        chk("t6_wait_rd", 32'(mem_rd), 32'h1);
        chk("t6_pre_pc",  pc,          32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rd",   32'(mem_rd), 32'h0);
        chk("t6_rst_busy", 32'(busy),   32'h0);
        chk("t6_rst_pc",   pc,          32'h0);
        chk("t6_rst_ir",   ir,          32'h0);
        chk("t6_rst_addr", mem_addr,    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3: timeout after 15 WAIT cycles without ack
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        cnt = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (mem_rd === 1'b1 && fetch_err === 1'b0) cnt++;
        end
        chk("t3_wait_cycles", 32'(cnt), 32'd15);
        tick();
        chk("t3_err",  32'(fetch_err), 32'h1);
        chk("t3_rd",   32'(mem_rd),    32'h0);
        chk("t3_busy", 32'(busy),      32'h0);
        fetch_req = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        pc_write = 1'b1; pc_src = 2'b01; branch_target = 32'h900;
        tick();
        tick();
        fetch_req = 1'b0; mem_ack = 1'b0; pc_write = 1'b0;
        chk("t3_err_sticky", 32'(fetch_err), 32'h1);
        chk("t3_err_idle",   32'(busy),      32'h0);
        chk("t3_err_pc",     pc,             32'h0);
        chk("t3_err_ir",     ir,             32'h0);

        rst_n = 1'b0;
        #1;
        chk("t3_rst_clear", 32'(fetch_err), 32'h0);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
